// File: rtl/video_timing_rx_if.sv
// Raster timing bundle: sync/DE inputs from the link plus recovered coordinates and measured geometry.
// timing_err exists only when VTR_EXPECT_CHECK_EN is defined.
interface video_timing_rx_if;
    logic        hs;
    logic        vs;
    logic        de;
    logic        de_o;
    logic [11:0] active_x;
    logic [10:0] active_y;
    logic        frame_start;
    logic        locked;
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [10:0] v_total;
    logic [10:0] v_active;
`ifdef VTR_EXPECT_CHECK_EN
    logic        timing_err;

    modport master (output hs, vs, de,
                    input  de_o, active_x, active_y, frame_start, locked,
                           h_total, h_active, v_total, v_active, timing_err);
    modport slave  (input  hs, vs, de,
                    output de_o, active_x, active_y, frame_start, locked,
                           h_total, h_active, v_total, v_active, timing_err);
`else
    modport master (output hs, vs, de,
                    input  de_o, active_x, active_y, frame_start, locked,
                           h_total, h_active, v_total, v_active);
    modport slave  (input  hs, vs, de,
                    output de_o, active_x, active_y, frame_start, locked,
                           h_total, h_active, v_total, v_active);
`endif
endinterface

// File: rtl/video_timing_rx.sv
// Sync/DE timing receiver: x/y recovery, geometry measurement, lock after LOCK_FRAMES matching frames; 2 clk in->out, no backpressure.
// Optional VTR_EXPECT_CHECK_EN adds timing_err, comparing each closed frame against the EXP_* geometry.
module video_timing_rx #(
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0,
    parameter int unsigned LOCK_FRAMES  = 3,
    parameter int unsigned EXP_H_TOTAL  = 2240,
    parameter int unsigned EXP_H_ACTIVE = 1920,
    parameter int unsigned EXP_V_TOTAL  = 1118,
    parameter int unsigned EXP_V_ACTIVE = 1080
) (
    input  logic             clk,
    input  logic             rst_n,
    video_timing_rx_if.slave vif
);
    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    typedef struct packed {
        logic [11:0] ht;
        logic [11:0] ha;
        logic [10:0] vt;
        logic [10:0] va;
    } meas_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, de_s1_q, de_s2_q;
    logic [11:0] hcnt_q, hcnt_d, xcnt_q, xcnt_d;
    logic [11:0] cur_ht_q, cur_ht_d, cur_ha_q, cur_ha_d;
    logic [10:0] vline_q, vline_d, vline_inc, ycnt_q, ycnt_d, ycnt_inc;
    logic        de_o_q, frame_start_q, locked_q, locked_d;
    logic [11:0] active_x_q, active_x_d;
    logic [10:0] active_y_q, active_y_d;
    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d, match_inc;
    meas_t       ref_q, ref_d, pub_q, pub_d, closed;
    logic        hs_lead, vs_lead, de_fall, hs_lost;

    assign hs_lead = (hs_s1_q == HS_POL) && (hs_s2_q != HS_POL);
    assign vs_lead = (vs_s1_q == VS_POL) && (vs_s2_q != VS_POL);
    assign de_fall = !de_s1_q && de_s2_q;
    assign hs_lost = (hcnt_q == 12'hFFF);

    assign hcnt_d     = hs_lead ? 12'd0 : (hs_lost ? hcnt_q : hcnt_q + 12'd1);
    assign cur_ht_d   = hs_lead ? hcnt_q + 12'd1 : cur_ht_q;
    assign xcnt_d     = de_s1_q ? xcnt_q + 12'd1 : 12'd0;
    assign cur_ha_d   = de_fall ? xcnt_q : cur_ha_q;
    assign ycnt_inc   = (de_fall && ycnt_q != 11'h7FF) ? ycnt_q + 11'd1 : ycnt_q;
    assign vline_inc  = (hs_lead && vline_q != 11'h7FF) ? vline_q + 11'd1 : vline_q;
    // Closed frame includes any hs/de event landing on the vs edge itself.
    assign closed     = {cur_ht_d, cur_ha_d, vline_inc, ycnt_inc};
    assign vline_d    = vs_lead ? 11'd0 : vline_inc;
    assign ycnt_d     = vs_lead ? 11'd0 : ycnt_inc;
    assign active_x_d = de_s1_q ? xcnt_q : 12'd0;
    assign active_y_d = de_s1_q ? ycnt_q : 11'd0;
    assign match_inc  = match_q + 4'd1;

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        ref_d   = ref_q;
        pub_d   = pub_q;
        if (hs_lost) begin
            state_d = SEARCH;
            match_d = 4'd0;
        end else if (vs_lead) begin
            ref_d = closed;
            case (state_q)
                SEARCH: begin
                    match_d = 4'd0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (closed == ref_q) begin
                        match_d = match_inc;
                        if (match_inc >= LOCK_N) begin
                            pub_d   = closed;
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (closed != ref_q) begin
                        match_d = 4'd0;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q       <= 1'b0;
            hs_s2_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            vs_s2_q       <= 1'b0;
            de_s1_q       <= 1'b0;
            de_s2_q       <= 1'b0;
            hcnt_q        <= 12'd0;
            xcnt_q        <= 12'd0;
            cur_ht_q      <= 12'd0;
            cur_ha_q      <= 12'd0;
            vline_q       <= 11'd0;
            ycnt_q        <= 11'd0;
            de_o_q        <= 1'b0;
            active_x_q    <= 12'd0;
            active_y_q    <= 11'd0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
            match_q       <= 4'd0;
            ref_q         <= '0;
            pub_q         <= '0;
        end else begin
            hs_s1_q       <= vif.hs;
            hs_s2_q       <= hs_s1_q;
            vs_s1_q       <= vif.vs;
            vs_s2_q       <= vs_s1_q;
            de_s1_q       <= vif.de;
            de_s2_q       <= de_s1_q;
            hcnt_q        <= hcnt_d;
            xcnt_q        <= xcnt_d;
            cur_ht_q      <= cur_ht_d;
            cur_ha_q      <= cur_ha_d;
            vline_q       <= vline_d;
            ycnt_q        <= ycnt_d;
            de_o_q        <= de_s1_q;
            active_x_q    <= active_x_d;
            active_y_q    <= active_y_d;
            frame_start_q <= vs_lead;
            locked_q      <= locked_d;
            state_q       <= state_d;
            match_q       <= match_d;
            ref_q         <= ref_d;
            pub_q         <= pub_d;
        end
    end

`ifdef VTR_EXPECT_CHECK_EN
    localparam meas_t EXP_M = {12'(EXP_H_TOTAL), 12'(EXP_H_ACTIVE),
                               11'(EXP_V_TOTAL), 11'(EXP_V_ACTIVE)};
    logic terr_q, terr_d;

    always_comb begin
        terr_d = terr_q;
        if (state_d == SEARCH) begin
            terr_d = 1'b0;
        end else if (vs_lead && state_q != SEARCH) begin
            terr_d = (closed != EXP_M);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= terr_d;
        end
    end

    assign vif.timing_err = terr_q;
`endif

    assign vif.de_o        = de_o_q;
    assign vif.active_x    = active_x_q;
    assign vif.active_y    = active_y_q;
    assign vif.frame_start = frame_start_q;
    assign vif.locked      = locked_q;
    assign vif.h_total     = pub_q.ht;
    assign vif.h_active    = pub_q.ha;
    assign vif.v_total     = pub_q.vt;
    assign vif.v_active    = pub_q.va;
endmodule
